// File: rtl/ps2_cmd_decoder.sv
// -----------------------------------------------------------------------------
// ps2_cmd_decoder
//
// Turns the byte stream from the PS/2 receiver into the 6-bit command vector
// used by ControlRTC. It follows scan-code set 2 prefixes (E0 = extended,
// F0 = break). It emits a one-clock pulse per accepted key press and
// suppresses typematic repeats. Runs entirely in the clk_nexys domain.
//
// Optional feature, selected by the macro PS2_TYPEMATIC_EN:
//   defined   : repeated makes of the aumenta/aum_cambio keys (code[5:4]) pulse
//               again, which gives auto-repeat increment/decrement.
//   undefined : every repeat is suppressed; one pulse per press/release.
//
// Ports:
//   clk           in   system clock (clk_nexys)
//   reset         in   asynchronous, active-low reset
//   rx_data[7:0]  in   received byte, valid only while rx_done_tick=1
//   rx_done_tick  in   one-clock strobe marking a new byte
//   code[5:0]     out  one-clock command pulses
//                      [5] aumenta, [4] aum_cambio, [3] programa,
//                      [2] reset request, [1] cambiomaq1, [0] cambiomaq2
//   key_held[5:0] out  level: make seen, break not yet seen, for each mapped key
//   prefix_err    out  one-clock pulse when a pending prefix times out
// -----------------------------------------------------------------------------
module ps2_cmd_decoder #(
    parameter logic [7:0] KEY_AUM        = 8'h1D,
    parameter logic [7:0] KEY_AUMC       = 8'h1B,
    parameter logic [7:0] KEY_PROG       = 8'h4D,
    parameter logic [7:0] KEY_RST        = 8'h2D,
    parameter logic [7:0] KEY_MAQ1       = 8'h1C,
    parameter logic [7:0] KEY_MAQ2       = 8'h23,
    parameter int         TIMEOUT_CYCLES = 200000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    output logic [5:0] code,
    output logic [5:0] key_held,
    output logic       prefix_err
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [7:0] BYTE_EXT = 8'hE0;
    localparam logic [7:0] BYTE_BRK = 8'hF0;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXT,
        S_BRK,
        S_EXT_BRK
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       code_q, code_d;
    logic [5:0]       held_q, held_d;
    logic             perr_q, perr_d;

    // Bit mask of the key a byte maps to (at most one bit set).
    logic [5:0]       key_mask;
    // Makes of held keys in this mask still pulse.
    logic [5:0]       repeat_mask;
    logic             is_status;

    // Checks run in ascending index order, so when two KEY_* values are equal
    // the later (higher) index overwrites the earlier one.
    always_comb begin
        key_mask = '0;
        if (rx_data == KEY_MAQ2) key_mask = 6'b000001;
        if (rx_data == KEY_MAQ1) key_mask = 6'b000010;
        if (rx_data == KEY_RST)  key_mask = 6'b000100;
        if (rx_data == KEY_PROG) key_mask = 6'b001000;
        if (rx_data == KEY_AUMC) key_mask = 6'b010000;
        if (rx_data == KEY_AUM)  key_mask = 6'b100000;
    end

`ifdef PS2_TYPEMATIC_EN
    assign repeat_mask = 6'b110000;
`else
    assign repeat_mask = 6'b000000;
`endif

    // Keyboard status bytes: ack, BAT ok, echo, resend.
    assign is_status = (rx_data == 8'hFA) || (rx_data == 8'hAA) ||
                       (rx_data == 8'hEE) || (rx_data == 8'hFE);

    // NOTE: every signal this block drives gets a default first. A path that
    // leaves a signal unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        code_d  = '0;
        held_d  = held_q;
        perr_d  = 1'b0;

        if (rx_done_tick) begin
            // A byte always restarts the prefix timer. It also wins over a
            // timeout that would expire in the same clock.
            cnt_d = '0;
            unique case (state_q)
                S_IDLE: begin
                    if (rx_data == BYTE_BRK) begin
                        state_d = S_BRK;
                    end else if (rx_data == BYTE_EXT) begin
                        state_d = S_EXT;
                    end else if (!is_status) begin
                        // Plain make: pulse unless this is a suppressed repeat.
                        code_d = key_mask & (~held_q | repeat_mask);
                        held_d = held_q | key_mask;
                    end
                end
                S_EXT: begin
                    if (rx_data == BYTE_BRK)      state_d = S_EXT_BRK;
                    else if (rx_data != BYTE_EXT) state_d = S_IDLE;
                end
                S_BRK: begin
                    if (rx_data == BYTE_EXT) begin
                        state_d = S_EXT_BRK;
                    end else if (rx_data != BYTE_BRK) begin
                        held_d  = held_q & ~key_mask;
                        state_d = S_IDLE;
                    end
                end
                S_EXT_BRK: begin
                    if (rx_data != BYTE_BRK && rx_data != BYTE_EXT) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end else if (state_q != S_IDLE) begin
            if (cnt_q == CNT_LAST) begin
                state_d = S_IDLE;
                cnt_d   = '0;
                perr_d  = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            code_q  <= '0;
            held_q  <= '0;
            perr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            code_q  <= code_d;
            held_q  <= held_d;
            perr_q  <= perr_d;
        end
    end

    assign code       = code_q;
    assign key_held   = held_q;
    assign prefix_err = perr_q;

endmodule

// File: tb/tb_ps2_cmd_decoder.sv
// -----------------------------------------------------------------------------
// tb_ps2_cmd_decoder
//
// Bench for ps2_cmd_decoder. It has four parts:
//   1. A table of directed vectors with hand-derived expected outputs.
//   2. Hand-written timeout and mid-sequence reset sequences.
//   3. Randomized byte traffic checked against a prefix-flag reference model.
//   4. A final summary line.
// The bench uses a short timeout so the timeout paths are reachable in a
// short run.
// -----------------------------------------------------------------------------
module tb_ps2_cmd_decoder;

    localparam int TO = 20;

`ifdef PS2_TYPEMATIC_EN
    localparam bit TYPEMATIC = 1'b1;
`else
    localparam bit TYPEMATIC = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_done_tick = 1'b0;
    logic [5:0] code;
    logic [5:0] key_held;
    logic       prefix_err;

    int n_pass  = 0;
    int n_total = 0;

    ps2_cmd_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .clk          (clk),
        .reset        (reset),
        .rx_data      (rx_data),
        .rx_done_tick (rx_done_tick),
        .code         (code),
        .key_held     (key_held),
        .prefix_err   (prefix_err)
    );

    always #5 clk = ~clk;

    // ---------------- reference model (prefix flags + idle timer) ------------
    logic [7:0] keys [6];
    bit         m_ext, m_brk;
    int         m_idle;
    logic [5:0] m_held, m_code;
    logic       m_perr;

    function automatic int key_index(input logic [7:0] b);
        int idx = -1;
        for (int i = 0; i < 6; i++) if (keys[i] == b) idx = i;
        return idx;
    endfunction

    task automatic model_reset();
        m_ext = 0; m_brk = 0; m_idle = 0;
        m_held = '0; m_code = '0; m_perr = 1'b0;
    endtask

    task automatic model_step(input logic t, input logic [7:0] b);
        int k;
        m_code = '0;
        m_perr = 1'b0;
        if (t) begin
            m_idle = 0;
            k = key_index(b);
            if (b == 8'hF0) m_brk = 1;
            else if (b == 8'hE0) m_ext = 1;
            else if (!m_ext && !m_brk && (b == 8'hFA || b == 8'hAA || b == 8'hEE || b == 8'hFE)) begin
                // status byte with no prefix: ignored
            end else begin
                if (!m_ext && k >= 0) begin
                    if (m_brk) m_held[k] = 1'b0;
                    else begin
                        if (!m_held[k] || (TYPEMATIC && k >= 4)) m_code[k] = 1'b1;
                        m_held[k] = 1'b1;
                    end
                end
                m_ext = 0; m_brk = 0;
            end
        end else if (m_ext || m_brk) begin
            m_idle++;
            if (m_idle == TO) begin
                m_ext = 0; m_brk = 0; m_idle = 0; m_perr = 1'b1;
            end
        end
    endtask

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Present one clock of input, then sample 1 time unit after the edge.
    task automatic step(input logic t, input logic [7:0] b);
        rx_done_tick = t;
        rx_data      = b;
        @(posedge clk);
        #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    function automatic logic [15:0] outs(input logic [5:0] c, input logic [5:0] h, input logic p);
        return {3'b000, c, h, p};
    endfunction

    // ---------------- directed vectors ----------------
    typedef struct {
        logic       tick;
        logic [7:0] data;
        logic [5:0] exp_code;
        logic [5:0] exp_held;
        logic       exp_perr;
    } vec_t;

    vec_t vecs [$];

    initial begin
        logic [5:0] rep;
        keys[0] = 8'h23; keys[1] = 8'h1C; keys[2] = 8'h2D;
        keys[3] = 8'h4D; keys[4] = 8'h1B; keys[5] = 8'h1D;
        rep = TYPEMATIC ? 6'b100000 : 6'b000000;

        // press W, repeat twice, release
        vecs.push_back('{1'b1, 8'h1D, 6'b100000, 6'b100000, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 6'b000000, 6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, rep,       6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, rep,       6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 6'b000000, 6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, 6'b000000, 6'b000000, 1'b0});
        // extended make and extended break of 1D: no effect
        vecs.push_back('{1'b1, 8'hE0, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'hE0, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, 6'b000000, 6'b000000, 1'b0});
        // back in IDLE: plain 1D fires again, then release
        vecs.push_back('{1'b1, 8'h1D, 6'b100000, 6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 6'b000000, 6'b100000, 1'b0});
        vecs.push_back('{1'b1, 8'h1D, 6'b000000, 6'b000000, 1'b0});
        // status bytes then D on back-to-back clocks
        vecs.push_back('{1'b1, 8'hAA, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'hFA, 6'b000000, 6'b000000, 1'b0});
        vecs.push_back('{1'b1, 8'h23, 6'b000001, 6'b000001, 1'b0});
        vecs.push_back('{1'b0, 8'h00, 6'b000000, 6'b000001, 1'b0});
        // S pressed while D held, then a repeat of D (never re-fires)
        vecs.push_back('{1'b1, 8'h1B, 6'b010000, 6'b010001, 1'b0});
        vecs.push_back('{1'b1, 8'h23, 6'b000000, 6'b010001, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 6'b000000, 6'b010001, 1'b0});
        vecs.push_back('{1'b1, 8'h23, 6'b000000, 6'b010000, 1'b0});
        vecs.push_back('{1'b1, 8'hF0, 6'b000000, 6'b010000, 1'b0});
        vecs.push_back('{1'b1, 8'h1B, 6'b000000, 6'b000000, 1'b0});

        // ---- reset state ----
        #2;
        check("reset_state", outs(code, key_held, prefix_err), 16'h0000);
        do_reset();
        check("after_release", outs(code, key_held, prefix_err), 16'h0000);

        // ---- table ----
        foreach (vecs[i]) begin
            step(vecs[i].tick, vecs[i].data);
            check($sformatf("vec%0d_%h", i, vecs[i].data), outs(code, key_held, prefix_err),
                  outs(vecs[i].exp_code, vecs[i].exp_held, vecs[i].exp_perr));
        end

        // ---- timeout: F0 then silence ----
        step(1'b1, 8'hF0);
        for (int i = 1; i < TO; i++) begin
            step(1'b0, 8'h00);
            if (prefix_err !== 1'b0) check($sformatf("early_perr_%0d", i), {15'd0, prefix_err}, 16'd0);
        end
        step(1'b0, 8'h00);
        check("timeout_perr", outs(code, key_held, prefix_err), outs(6'b0, 6'b0, 1'b1));
        step(1'b0, 8'h00);
        check("timeout_perr_one_clk", outs(code, key_held, prefix_err), 16'h0000);
        step(1'b1, 8'h4D);
        check("after_timeout_P", outs(code, key_held, prefix_err), outs(6'b001000, 6'b001000, 1'b0));

        // ---- byte in the same clock the timeout would fire wins ----
        step(1'b1, 8'hF0);
        for (int i = 1; i < TO; i++) step(1'b0, 8'h00);
        step(1'b1, 8'h4D);
        check("tick_beats_timeout", outs(code, key_held, prefix_err), 16'h0000);
        step(1'b0, 8'h00);
        check("no_late_perr", outs(code, key_held, prefix_err), 16'h0000);

        // ---- reset mid-sequence ----
        step(1'b1, 8'h2D);
        check("R_press", outs(code, key_held, prefix_err), outs(6'b000100, 6'b000100, 1'b0));
        step(1'b1, 8'hF0);
        #2 reset = 1'b0;
        #1;
        check("async_reset", outs(code, key_held, prefix_err), 16'h0000);
        @(posedge clk);
        #1 reset = 1'b1;
        step(1'b1, 8'h1C);
        check("post_reset_A", outs(code, key_held, prefix_err), outs(6'b000010, 6'b000010, 1'b0));
        step(1'b1, 8'h2D);
        check("post_reset_R", outs(code, key_held, prefix_err), outs(6'b000100, 6'b000110, 1'b0));

        // ---- randomized traffic against the reference model ----
        do_reset();
        model_reset();
        for (int blk = 0; blk < 10; blk++) begin
            int rate;
            rate = (blk % 3 == 0) ? 4 : ((blk % 3 == 1) ? 40 : 90);
            for (int n = 0; n < 250; n++) begin
                logic       t;
                logic [7:0] b;
                int         sel;
                t   = ($urandom_range(0, 99) < rate);
                sel = $urandom_range(0, 9);
                if (sel < 5)       b = keys[$urandom_range(0, 5)];
                else if (sel == 5) b = 8'hF0;
                else if (sel == 6) b = 8'hE0;
                else if (sel == 7) b = ($urandom_range(0, 1) != 0) ? 8'hFA : 8'hAA;
                else               b = 8'($urandom_range(0, 255));
                step(t, b);
                model_step(t, b);
                check($sformatf("rand_b%0d_n%0d", blk, n), outs(code, key_held, prefix_err),
                      outs(m_code, m_held, m_perr));
                if ($countones(code) > 1)
                    check("onehot_code", {10'd0, code}, 16'd0);
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
